// File: rtl/vga_fb_arbiter_if.sv
// CPU register-style access path into the framebuffer arbiter.
// Handshake: cpu_req is a level held, with cpu_we/cpu_addr/cpu_wdata stable, until the
// one-cycle cpu_ack pulse; cpu_rdata is valid with cpu_ack and held until the next read completes.
interface vga_fb_arbiter_if #(
   parameter int AW = 4,
   parameter int DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port line memory arbiter: VGA scanout fetch (strict priority) vs CPU read/write,
// with a sticky underrun flag for overwritten or late line fetches.
module vga_fb_arbiter #(
   parameter int AW            = 4,
   parameter int DW            = 32,
   parameter int SCAN_DEADLINE = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                scan_req,
   input  logic [AW-1:0]       scan_row,
   output logic [DW-1:0]       line_data,
   output logic                line_valid,
   output logic                underrun,
   input  logic                underrun_clr,
   vga_fb_arbiter_if.slave     cpu,
   output logic                mem_en,
   output logic                mem_we,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_wdata,
   input  logic [DW-1:0]       mem_rdata,
   output logic [2:0]          dbg_state
);

   localparam int            CW     = $clog2(SCAN_DEADLINE + 1);
   localparam logic [CW-1:0] DL_MAX = CW'(SCAN_DEADLINE);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SCAN_RD  = 3'd1,
      SCAN_CAP = 3'd2,
      CPU_RD   = 3'd3,
      CPU_CAP  = 3'd4,
      CPU_WR   = 3'd5,
      CPU_DONE = 3'd6
   } state_t;

   state_t        state, state_nx;
   logic          scan_grant, cpu_grant;
   logic          scan_pend;
   logic [AW-1:0] scan_row_q;
   logic [AW-1:0] op_addr;
   logic [DW-1:0] op_wdata;
   logic [CW-1:0] dl_cnt;
   logic          dl_inc, dl_hit, underrun_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      scan_grant = 1'b0;
      cpu_grant  = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      cpu.cpu_ack = 1'b0;
      case (state)
         IDLE: begin
            if (scan_pend) begin
               scan_grant = 1'b1;
               state_nx   = SCAN_RD;
            end else if (cpu.cpu_req) begin
               cpu_grant = 1'b1;
               state_nx  = cpu.cpu_we ? CPU_WR : CPU_RD;
            end
         end
         SCAN_RD: begin
            mem_en   = 1'b1;
            state_nx = SCAN_CAP;
         end
         SCAN_CAP: state_nx = IDLE;
         CPU_RD: begin
            mem_en   = 1'b1;
            state_nx = CPU_CAP;
         end
         CPU_CAP: state_nx = CPU_DONE;
         CPU_WR: begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            state_nx = CPU_DONE;
         end
         // Requests are not sampled here, so a cpu_req still high during the ack is not re-granted.
         CPU_DONE: begin
            cpu.cpu_ack = 1'b1;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign mem_addr  = op_addr;
   assign mem_wdata = op_wdata;
   assign dbg_state = state;

   // A new scan_req restarts the pending slot; issuing in the same cycle still fetches the old row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_pend  <= 1'b0;
         scan_row_q <= '0;
      end else if (scan_req) begin
         scan_pend  <= 1'b1;
         scan_row_q <= scan_row;
      end else if (scan_grant) begin
         scan_pend  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_addr  <= '0;
         op_wdata <= '0;
      end else if (scan_grant) begin
         op_addr  <= scan_row_q;
      end else if (cpu_grant) begin
         op_addr  <= cpu.cpu_addr;
         op_wdata <= cpu.cpu_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_data     <= '0;
         line_valid    <= 1'b0;
         cpu.cpu_rdata <= '0;
      end else begin
         line_valid <= (state == SCAN_CAP);
         if (state == SCAN_CAP) line_data     <= mem_rdata;
         if (state == CPU_CAP)  cpu.cpu_rdata <= mem_rdata;
      end
   end

   // Deadline counter runs while a fetch is pending or in flight and saturates at the limit.
   assign dl_inc       = scan_pend || (state == SCAN_RD) || (state == SCAN_CAP);
   assign dl_hit       = !scan_req && dl_inc && (dl_cnt == DL_MAX - CW'(1));
   assign underrun_set = (scan_req && scan_pend) || dl_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          dl_cnt <= '0;
      else if (scan_req)                   dl_cnt <= '0;
      else if (dl_inc && dl_cnt != DL_MAX) dl_cnt <= dl_cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            underrun <= 1'b0;
      else if (underrun_set) underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
   end

endmodule
